// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg
// Shared types and constants for the tick timer arbiter.
//   state_e       : arbiter/timer FSM states
//   TICK_DIV_50MS : clk_in cycles per 50 ms tick at 25 MHz
//   CLK_HZ        : nominal clk_in frequency
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int TICK_DIV_50MS = 1250000;
  localparam int CLK_HZ        = 25000000;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Modulo-TICK_DIV counter producing a one-cycle tick strobe.
//   clk_in : system clock
//   rst    : asynchronous active-high reset
//   clr    : synchronous clear of the count (wins over en)
//   en     : count enable
//   tick   : high while enabled in the cycle the count equals TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 1250000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter
// Fixed-priority arbiter sharing one coarse countdown timer between requesters.
//   clk_in    : system clock (25 MHz)
//   rst       : asynchronous active-high reset
//   req       : level request per requester, index 0 highest priority
//   dur       : per-requester duration in ticks, sampled at grant
//   cancel    : abort of the running timer
//   gnt       : one-hot grant, held during LOAD and RUN
//   busy      : high in LOAD and RUN
//   done      : one-cycle expiry pulse
//   done_id   : index of the expired requester, holds between pulses
//   remaining : ticks left in the current run, 0 when idle
//   tick      : tick strobe, only in RUN
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_50MS,
  parameter int N_REQ    = 3,
  parameter int DUR_W    = 8
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DUR_W-1:0]     dur,
  input  logic                       cancel,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [DUR_W-1:0]           remaining,
  output logic                       tick
);

  localparam int ID_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   mask_q, mask_d;
  logic [ID_W-1:0]    idx_q, idx_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic               done_q, done_d;

  logic [N_REQ-1:0]   eligible;
  logic [ID_W-1:0]    sel_idx;
  logic [N_REQ-1:0]   mask_set;
  logic               abort;
  logic               run_tick;

  // Requesters that already expired stay masked until they drop req,
  // so a held request cannot immediately re-trigger the timer.
  assign eligible = req & ~mask_q;

  // Lowest set index wins; scanning downward lets the lowest overwrite.
  always_comb begin
    sel_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = ID_W'(i);
    end
  end

  // Losing the granted request is treated exactly like a cancel.
  assign abort = cancel | ~(|(req & gnt_q));

  // The prescaler is held at zero outside RUN, so every run starts
  // with a full TICK_DIV period before its first tick.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (state_q != RUN),
    .en     (state_q == RUN),
    .tick   (run_tick)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    mask_set  = '0;

    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = LOAD;
          gnt_d   = N_REQ'(1) << sel_idx;
          idx_d   = sel_idx;
          rem_d   = dur[sel_idx*DUR_W +: DUR_W];
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
          rem_d   = '0;
        end else if (rem_q == '0) begin
          state_d   = DONE;
          gnt_d     = '0;
          done_d    = 1'b1;
          done_id_d = idx_q;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort is checked first so it beats a coincident final tick.
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
          rem_d   = '0;
        end else if (run_tick) begin
          rem_d = rem_q - DUR_W'(1);
          if (rem_q == DUR_W'(1)) begin
            state_d   = DONE;
            gnt_d     = '0;
            done_d    = 1'b1;
            done_id_d = idx_q;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        mask_set = N_REQ'(1) << idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // A low req clears its mask bit even in the cycle it would be set.
  assign mask_d = (mask_q | mask_set) & req;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      done_id_q <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      done_id_q <= done_id_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == LOAD) || (state_q == RUN);
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign remaining = rem_q;
  assign tick      = run_tick;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
module tb_tick_timer_arbiter;

  localparam int TICK_DIV = 4;
  localparam int N_REQ    = 3;
  localparam int DUR_W    = 8;

  logic                   clk_in = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*DUR_W-1:0] dur;
  logic                   cancel;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [1:0]             done_id;
  logic [DUR_W-1:0]       remaining;
  logic                   tick;

  int err_cnt  = 0;
  int chk_cnt  = 0;
  int tick_seen = 0;
  int done_seen = 0;

  tick_timer_arbiter #(
    .TICK_DIV (TICK_DIV),
    .N_REQ    (N_REQ),
    .DUR_W    (DUR_W)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .req       (req),
    .dur       (dur),
    .cancel    (cancel),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .remaining (remaining),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and tallying strobes.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_in);
      tick_seen += int'(tick);
      done_seen += int'(done);
    end
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    dur    = '0;
    cancel = 1'b0;
    cyc(2);
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_rem", 32'(remaining), 0);
    check_eq("rst_tick", 32'(tick), 0);
    rst = 1'b0;
    cyc(2);

    // Single run: requester 1, dur 3.
    req = 3'b010;
    dur = {8'd0, 8'd3, 8'd0};
    cyc(1);
    tick_seen = 0; done_seen = 0;
    check_eq("s1_gnt_G", 32'(gnt), 32'b010);
    check_eq("s1_busy_G", 32'(busy), 1);
    check_eq("s1_rem_G", 32'(remaining), 3);
    cyc(4);
    check_eq("s1_tick_G4", 32'(tick), 1);
    check_eq("s1_rem_G4", 32'(remaining), 3);
    cyc(1);
    check_eq("s1_rem_G5", 32'(remaining), 2);
    cyc(7);
    check_eq("s1_tick_G12", 32'(tick), 1);
    check_eq("s1_rem_G12", 32'(remaining), 1);
    check_eq("s1_done_G12", 32'(done), 0);
    cyc(1);
    check_eq("s1_done_G13", 32'(done), 1);
    check_eq("s1_id_G13", 32'(done_id), 1);
    check_eq("s1_gnt_G13", 32'(gnt), 0);
    check_eq("s1_ticks", 32'(tick_seen), 3);
    req = 3'b000;
    cyc(2);
    check_eq("s1_done_after", 32'(done), 0);

    // Priority and queueing.
    req = 3'b110;
    dur = {8'd1, 8'd2, 8'd1};
    cyc(1);
    check_eq("s2_gnt_r1", 32'(gnt), 32'b010);
    cyc(2);
    req = 3'b111;
    cyc(3);
    check_eq("s2_no_preempt", 32'(gnt), 32'b010);
    cyc(4);
    check_eq("s2_done_r1", 32'(done), 1);
    check_eq("s2_id_r1", 32'(done_id), 1);
    cyc(1);
    check_eq("s2_gap_gnt", 32'(gnt), 0);
    cyc(1);
    check_eq("s2_gnt_r0", 32'(gnt), 32'b001);
    check_eq("s2_rem_r0", 32'(remaining), 1);
    cyc(5);
    check_eq("s2_done_r0", 32'(done), 1);
    check_eq("s2_id_r0", 32'(done_id), 0);
    cyc(2);
    check_eq("s2_gnt_r2", 32'(gnt), 32'b100);
    req = 3'b000;
    cyc(1);
    check_eq("s2_drop_gnt", 32'(gnt), 0);
    check_eq("s2_drop_rem", 32'(remaining), 0);
    check_eq("s2_drop_done", 32'(done), 0);
    cyc(1);

    // Zero duration and mask.
    req = 3'b100;
    dur = {8'd0, 8'd9, 8'd9};
    cyc(1);
    check_eq("s3_gnt", 32'(gnt), 32'b100);
    cyc(1);
    check_eq("s3_done", 32'(done), 1);
    check_eq("s3_id", 32'(done_id), 2);
    check_eq("s3_gnt_done", 32'(gnt), 0);
    cyc(4);
    check_eq("s3_masked_gnt", 32'(gnt), 0);
    check_eq("s3_masked_busy", 32'(busy), 0);
    req = 3'b000;
    cyc(1);
    req = 3'b100;
    cyc(1);
    check_eq("s3_regrant", 32'(gnt), 32'b100);
    cyc(1);
    req = 3'b000;
    cyc(2);

    // Cancel coinciding with the final tick.
    req = 3'b001;
    dur = {8'd0, 8'd0, 8'd2};
    cyc(1);
    done_seen = 0;
    cyc(8);
    check_eq("s4_tick_last", 32'(tick), 1);
    check_eq("s4_rem_last", 32'(remaining), 1);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    check_eq("s4_cancel_busy", 32'(busy), 0);
    check_eq("s4_cancel_rem", 32'(remaining), 0);
    check_eq("s4_cancel_id_hold", 32'(done_id), 2);
    req = 3'b000;
    cyc(2);
    check_eq("s4_no_done", 32'(done_seen), 0);

    // Granted request dropped mid-run.
    req = 3'b010;
    dur = {8'd0, 8'd6, 8'd0};
    cyc(1);
    cyc(6);
    check_eq("s5_rem_mid", 32'(remaining), 5);
    req = 3'b000;
    cyc(1);
    check_eq("s5_drop_gnt", 32'(gnt), 0);
    check_eq("s5_drop_rem", 32'(remaining), 0);
    cyc(1);

    // Asynchronous reset mid-run, then re-grant with full duration.
    req = 3'b010;
    cyc(1);
    cyc(5);
    check_eq("s6_rem_pre", 32'(remaining), 5);
    #2;
    rst = 1'b1;
    #1;
    check_eq("s6_rst_gnt", 32'(gnt), 0);
    check_eq("s6_rst_busy", 32'(busy), 0);
    check_eq("s6_rst_rem", 32'(remaining), 0);
    check_eq("s6_rst_id", 32'(done_id), 0);
    check_eq("s6_rst_tick", 32'(tick), 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check_eq("s6_regrant", 32'(gnt), 32'b010);
    check_eq("s6_full_dur", 32'(remaining), 6);
    req = 3'b000;
    cyc(2);

    // Maximum duration.
    req = 3'b001;
    dur = {8'd0, 8'd0, 8'd255};
    cyc(1);
    tick_seen = 0; done_seen = 0;
    check_eq("s7_rem_G", 32'(remaining), 255);
    cyc(1020);
    check_eq("s7_tick_last", 32'(tick), 1);
    check_eq("s7_rem_last", 32'(remaining), 1);
    check_eq("s7_done_early", 32'(done), 0);
    cyc(1);
    check_eq("s7_done", 32'(done), 1);
    check_eq("s7_id", 32'(done_id), 0);
    check_eq("s7_ticks", 32'(tick_seen), 255);
    check_eq("s7_done_cnt", 32'(done_seen), 1);
    req = 3'b000;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
